cordic_mul_pipe: RTL and testbench

//  Parametrised, pipelined signed multiplier for the CORDIC datapath (gain/scale stage).

---
 rtl/cordic_mul_pkg.sv | 23 ++
 rtl/cordic_mul_round_sat.sv | 38 +++
 rtl/cordic_mul_pipe.sv | 130 +++++++++++++
 tb/tb_cordic_mul_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_mul_pkg.sv
// Shared widths, saturation bounds and pipeline-depth constant for the CORDIC gain multiplier.
// Optional feature macro: CORDIC_MUL_ROUND_EN (round half up + saturate, one extra stage).
package cordic_mul_pkg;

`ifdef CORDIC_MUL_ROUND_EN
  localparam int CORDIC_MUL_EXTRA_STAGE = 1;
`else
  localparam int CORDIC_MUL_EXTRA_STAGE = 0;
`endif

  function automatic int PROD_W(input int a, input int b);
    return a + b;
  endfunction

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/cordic_mul_round_sat.sv
// Combinational round-half-up, arithmetic shift and signed saturation of the full product.
// Only exists when CORDIC_MUL_ROUND_EN is defined.
`ifdef CORDIC_MUL_ROUND_EN
module cordic_mul_round_sat
  import cordic_mul_pkg::*;
#(
  parameter int PW         = 24,
  parameter int DOUT_W     = 24,
  parameter int FRAC_SHIFT = 0
) (
  input  logic signed [PW-1:0] p,
  output logic [DOUT_W-1:0]    s,
  output logic                 ovf
);
  localparam int HS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic signed [PW:0] HALF = (PW + 1)'((FRAC_SHIFT > 0) ? (64'd1 << HS) : 64'd0);

  // One guard bit so adding the half-LSB can never wrap.
  logic signed [PW:0] sum;
  logic signed [PW:0] sh;
  logic signed [63:0] sh64;

  always_comb begin
    sum  = (PW + 1)'(p) + HALF;
    sh   = sum >>> FRAC_SHIFT;
    sh64 = 64'(sh);
    s    = DOUT_W'(sh);
    ovf  = 1'b0;
    if (sh64 > sat_max(DOUT_W)) begin
      s   = DOUT_W'(sat_max(DOUT_W));
      ovf = 1'b1;
    end else if (sh64 < sat_min(DOUT_W)) begin
      s   = DOUT_W'(sat_min(DOUT_W));
      ovf = 1'b1;
    end
  end
endmodule
`endif

// File: rtl/cordic_mul_pipe.sv
// Pipelined signed multiplier with valid/ready and whole-pipe stall for the CORDIC gain stage.
// Optional feature macro: CORDIC_MUL_ROUND_EN (round/saturate path, latency NUM_STAGE+1).
module cordic_mul_pipe
  import cordic_mul_pkg::*;
#(
  parameter int DIN0_W     = 12,
  parameter int DIN1_W     = 12,
  parameter int DOUT_W     = 24,
  parameter int FRAC_SHIFT = 0,
  parameter int NUM_STAGE  = 3
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIN0_W-1:0] din0,
  input  logic [DIN1_W-1:0] din1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DOUT_W-1:0] dout,
  output logic              ovf
);
  localparam int PW  = PROD_W(DIN0_W, DIN1_W);
  localparam int LAT = NUM_STAGE + CORDIC_MUL_EXTRA_STAGE;
  localparam int PP  = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

  logic                     ce;
  logic [LAT:1]             vld_q, vld_d;
  logic signed [DIN0_W-1:0] mul_a;
  logic signed [DIN1_W-1:0] mul_b;
  logic signed [PW-1:0]     prod_q [PP];
  logic signed [PW-1:0]     prod_d [PP];
  logic signed [PW-1:0]     p_fin;

  assign out_valid = vld_q[LAT];
  assign ce        = !(out_valid && !out_ready);
  assign in_ready  = ce;

  // With a single stage the product of the raw inputs is the only register.
  if (NUM_STAGE > 1) begin : g_opreg
    logic [DIN0_W-1:0] a_q, a_d;
    logic [DIN1_W-1:0] b_q, b_d;
    always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (ce) begin
        a_d = din0;
        b_d = din1;
      end
    end
    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
    assign mul_a = a_q;
    assign mul_b = b_q;
  end else begin : g_noopreg
    assign mul_a = din0;
    assign mul_b = din1;
  end

  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < PP; i++) prod_d[i] = prod_q[i];
    if (ce) begin
      vld_d[1] = in_valid;
      for (int i = 2; i <= LAT; i++) vld_d[i] = vld_q[i-1];
      prod_d[0] = PW'(mul_a) * PW'(mul_b);
      for (int i = 1; i < PP; i++) prod_d[i] = prod_q[i-1];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_q <= '0;
      for (int i = 0; i < PP; i++) prod_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      prod_q <= prod_d;
    end
  end

  assign p_fin = prod_q[PP-1];

`ifdef CORDIC_MUL_ROUND_EN
  logic [DOUT_W-1:0] rs_s, dout_q, dout_d;
  logic              rs_ovf, ovf_q, ovf_d;

  cordic_mul_round_sat #(
    .PW        (PW),
    .DOUT_W    (DOUT_W),
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_round_sat (
    .p  (p_fin),
    .s  (rs_s),
    .ovf(rs_ovf)
  );

  always_comb begin
    dout_d = dout_q;
    ovf_d  = ovf_q;
    if (ce) begin
      dout_d = rs_s;
      ovf_d  = rs_ovf;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout = dout_q;
  assign ovf  = ovf_q && out_valid;
`else
  assign dout = DOUT_W'(p_fin >>> FRAC_SHIFT);
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_mul_pipe.sv
// Randomised scoreboard bench for cordic_mul_pipe: a 12x12->24 instance and a 12x12->12 (>>>11) instance.
module tb_cordic_mul_pipe;
`ifdef CORDIC_MUL_ROUND_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = 3 + EXTRA;

  typedef struct {
    longint d;
    bit     o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, ovf;
  logic [11:0] din0, din1;
  logic [23:0] dout;

  logic        in_valid2, in_ready2, out_valid2, ovf2;
  logic [11:0] a2, b2, dout2;

  int   n_chk = 0, n_pass = 0;
  int   n_in = 0, n_out = 0;
  bit   mon_en = 0;
  exp_t sbq[$];

  cordic_mul_pipe #(
    .DIN0_W(12), .DIN1_W(12), .DOUT_W(24), .FRAC_SHIFT(0), .NUM_STAGE(3)
  ) dut (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .ovf(ovf)
  );

  cordic_mul_pipe #(
    .DIN0_W(12), .DIN1_W(12), .DOUT_W(12), .FRAC_SHIFT(11), .NUM_STAGE(3)
  ) dut2 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .din0(a2), .din1(b2), .out_valid(out_valid2), .out_ready(1'b1),
    .dout(dout2), .ovf(ovf2)
  );

  // Reference: exact product, then shift and either wrap or round+clamp.
  function automatic longint ref_mul(input longint a, input longint b, input int fs,
                                     input int dw, output bit ov);
    longint p, s;
`ifdef CORDIC_MUL_ROUND_EN
    longint mx, mn;
`endif
    p  = a * b;
    ov = 1'b0;
`ifdef CORDIC_MUL_ROUND_EN
    if (fs > 0) p = p + (longint'(1) << (fs - 1));
    s  = p >>> fs;
    mx = (longint'(1) << (dw - 1)) - 1;
    mn = -(longint'(1) << (dw - 1));
    if (s > mx) begin
      s = mx; ov = 1'b1;
    end else if (s < mn) begin
      s = mn; ov = 1'b1;
    end
`else
    s = p >>> fs;
    s = (s <<< (64 - dw)) >>> (64 - dw);
`endif
    return s;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Compare process: every cycle, decide what transfers at the coming edge.
  bit          stall_prev = 0;
  logic [23:0] dout_prev;
  logic        ovf_prev;
  always @(negedge clk) begin
    exp_t e;
    bit   o;
    if (mon_en) begin
      if (rst) begin
        sbq.delete();
        stall_prev = 0;
      end else begin
        check("in_ready", in_ready, !(out_valid && !out_ready));
        if (!out_valid) check("ovf_idle", ovf, 0);
        if (stall_prev) begin
          check("stall_valid", out_valid, 1);
          check("stall_dout", dout, dout_prev);
          check("stall_ovf", ovf, ovf_prev);
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (sbq.size() == 0) check("unexpected_out", 1, 0);
          else begin
            e = sbq.pop_front();
            check("dout", $signed(dout), e.d);
            check("ovf", ovf, e.o);
          end
        end
        if (in_valid && in_ready) begin
          n_in++;
          e.d = ref_mul($signed(din0), $signed(din1), 0, 24, o);
          e.o = o;
          sbq.push_back(e);
        end
        stall_prev = out_valid && !out_ready;
        dout_prev  = dout;
        ovf_prev   = ovf;
      end
    end
  end

  task automatic send_one(input logic [11:0] a, input logic [11:0] b, output int lat);
    in_valid = 1; din0 = a; din1 = b;
    @(posedge clk); #1;
    in_valid = 0; lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send2(input logic [11:0] a, input logic [11:0] b, output int lat);
    check("in_ready2", in_ready2, 1);
    in_valid2 = 1; a2 = a; b2 = b;
    @(posedge clk); #1;
    in_valid2 = 0; lat = 1;
    while (!out_valid2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain(input string nm);
    int k = 0;
    in_valid = 0; out_ready = 1;
    while (sbq.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check(nm, sbq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     lat, i0, o0;
    bit     o;
    longint v;
    rst = 1; in_valid = 0; din0 = 0; din1 = 0; out_ready = 1;
    in_valid2 = 0; a2 = 0; b2 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_valid2", out_valid2, 0);
    rst = 0; mon_en = 1;
    @(posedge clk); #1;
    check("in_ready_after_rst", in_ready, 1);

    // Directed: most negative squared, fixed latency.
    send_one(12'h800, 12'h800, lat);
    check("t1_latency", lat, LAT);
    check("t1_dout", dout, 24'h400000);
    drain("t1_drain");

    // Continuous stream: one result per cycle once the pipe fills.
    o0 = n_out;
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1; din0 = 12'($urandom); din1 = 12'($urandom);
      @(posedge clk); #1;
    end
    check("t2_throughput", n_out - o0, 1000 - LAT);
    drain("t2_drain");
    check("t2_count", n_out - o0, 1000);

    // Random gaps and backpressure.
    i0 = n_in; o0 = n_out;
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      din0      = 12'($urandom);
      din1      = 12'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    drain("t3_drain");
    check("t3_count", n_out - o0, n_in - i0);

    // Reset with results in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; din0 = 12'($urandom); din1 = 12'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 0; rst = 1;
    @(posedge clk); #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_ovf", ovf, 0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t6_quiet", out_valid, 0);
    end
    send_one(12'd100, 12'hF9C, lat);
    check("t6_latency", lat, LAT);
    check("t6_dout", $signed(dout), -10000);
    drain("t6_drain");

    // Scaled instance: boundary values.
    send2(12'd2047, 12'd2047, lat);
    check("t4_latency", lat, LAT);
    check("t4_max_dout", $signed(dout2), 2046);
    check("t4_max_ovf", ovf2, 0);
    @(posedge clk); #1;
    send2(12'h800, 12'h800, lat);
`ifdef CORDIC_MUL_ROUND_EN
    check("t4_neg_dout", $signed(dout2), 2047);
    check("t4_neg_ovf", ovf2, 1);
`else
    check("t4_neg_dout", $signed(dout2), -2048);
    check("t4_neg_ovf", ovf2, 0);
`endif
    @(posedge clk); #1;
    send2(12'd3, 12'd1024, lat);
`ifdef CORDIC_MUL_ROUND_EN
    check("t5_pos_half", $signed(dout2), 2);
`else
    check("t5_pos_half", $signed(dout2), 1);
`endif
    @(posedge clk); #1;
    send2(12'hFFD, 12'd1024, lat);
`ifdef CORDIC_MUL_ROUND_EN
    check("t5_neg_half", $signed(dout2), -1);
`else
    check("t5_neg_half", $signed(dout2), -2);
`endif
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      a2 = 12'($urandom); b2 = 12'($urandom);
      v = ref_mul($signed(a2), $signed(b2), 11, 12, o);
      send2(a2, b2, lat);
      check("t4_rand_dout", $signed(dout2), v);
      check("t4_rand_ovf", ovf2, o);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
